// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: receive-side VGA raster measurement and lock.
// Emits each active pixel with recovered X/Y once the raster is stable.
module vga_timing_decoder #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 1024,
  parameter int H_SYNC_BACK = 361,
  parameter int V_SYNC_BACK = 42,
  parameter int LOCK_FRAMES = 2,
  parameter int PIX_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_n,
  input  logic             vsync_n,
  input  logic [PIX_W-1:0] pixel_in,
  output logic             px_valid,
  output logic [PIX_W-1:0] px_data,
  output logic [10:0]      px_x,
  output logic [10:0]      px_y,
  output logic             frame_start,
  output logic             locked,
  output logic             err,
  output logic [11:0]      line_len,
  output logic [11:0]      frame_lines
);

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } state_t;

  localparam logic [11:0] HB =
    12'(H_SYNC_BACK);
  localparam logic [11:0] HE =
    12'(H_SYNC_BACK + H_ACTIVE);
  localparam logic [10:0] VB =
    11'(V_SYNC_BACK);
  localparam logic [10:0] VE =
    11'(V_SYNC_BACK + V_ACTIVE);
  localparam logic [7:0] GOOD_LAST =
    8'(LOCK_FRAMES - 1);

  state_t           state;
  state_t           nextState;
  logic             hsS1;
  logic             vsS1;
  logic             hsPrev;
  logic             vsPrev;
  logic [PIX_W-1:0] pixS1;
  logic [11:0]      hcnt;
  logic [11:0]      hNext;
  logic [11:0]      refLine;
  logic [10:0]      vcnt;
  logic [10:0]      vNext;
  logic [10:0]      refFrame;
  logic             refLineOk;
  logic             refFrameOk;
  logic [7:0]       good;
  logic             hsEdge;
  logic             vsEdge;
  logic             hSat;
  logic             vSat;
  logic             lineBad;
  logic             frameBad;
  logic             mismatch;
  logic             hit;

  // Sample the link once and keep the prior sample for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      hsS1   <= 1'b1;
      vsS1   <= 1'b1;
      hsPrev <= 1'b1;
      vsPrev <= 1'b1;
      pixS1  <= '0;
    end else begin
      hsS1   <= hsync_n;
      vsS1   <= vsync_n;
      hsPrev <= hsS1;
      vsPrev <= vsS1;
      pixS1  <= pixel_in;
    end
  end

  // Counter next values, timing mismatch and active-window decode
  always_comb begin
    hsEdge = !hsS1 && hsPrev;
    vsEdge = !vsS1 && vsPrev;
    hSat   = hcnt == 12'hFFF;
    vSat   = vcnt == 11'h7FF;
    hNext  = hSat ? hcnt : hcnt + 12'd1;
    if (hsEdge)
      hNext = '0;
    vNext = vcnt;
    if (hsEdge && !vSat)
      vNext = vcnt + 11'd1;
    if (vsEdge)
      vNext = '0;
    lineBad =
      (hsEdge && !hSat && refLineOk &&
       (hcnt + 12'd1 != refLine)) ||
      (!hsEdge && hcnt == 12'hFFE);
    frameBad =
      (vsEdge && refFrameOk &&
       vcnt != refFrame) ||
      (hsEdge && !vsEdge &&
       vcnt == 11'h7FE);
    mismatch = lineBad || frameBad;
    hit = state == LOCKED && !mismatch &&
          hNext >= HB && hNext < HE &&
          vNext >= VB && vNext < VE;
  end

  // Lock state machine next state
  always_comb begin
    nextState = state;
    unique case (state)
      SEARCH:
        if (vsEdge)
          nextState = CHECK;
      CHECK:
        if (mismatch)
          nextState = SEARCH;
        else if (vsEdge && refFrameOk &&
                 good == GOOD_LAST)
          nextState = LOCKED;
      LOCKED:
        if (mismatch)
          nextState = SEARCH;
      default:
        nextState = SEARCH;
    endcase
  end

  // Timing counters, reference capture and lock state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      hcnt       <= 12'hFFF;
      vcnt       <= 11'h7FF;
      refLine    <= '0;
      refFrame   <= '0;
      refLineOk  <= 1'b0;
      refFrameOk <= 1'b0;
      good       <= '0;
    end else begin
      state <= nextState;
      hcnt  <= hNext;
      vcnt  <= vNext;
      if (state == SEARCH && vsEdge) begin
        refLineOk  <= 1'b0;
        refFrameOk <= 1'b0;
        good       <= '0;
      end
      if (state == CHECK) begin
        if (hsEdge && !hSat && !refLineOk) begin
          refLine   <= hcnt + 12'd1;
          refLineOk <= 1'b1;
        end
        if (vsEdge && !refFrameOk) begin
          refFrame   <= vcnt;
          refFrameOk <= 1'b1;
        end
        if (vsEdge && refFrameOk)
          good <= good + 8'd1;
      end
    end
  end

  // Registered pixel stream and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      px_valid    <= 1'b0;
      px_data     <= '0;
      px_x        <= '0;
      px_y        <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      px_valid    <= hit;
      frame_start <= hit && hNext == HB &&
                     vNext == VB;
      if (hit) begin
        px_x    <= 11'(hNext - HB);
        px_y    <= vNext - VB;
        px_data <= pixS1;
      end
      locked <= nextState == LOCKED;
      err    <= state == LOCKED && mismatch;
      if (hsEdge && !hSat)
        line_len <= hcnt + 12'd1;
      if (vsEdge)
        frame_lines <= {1'b0, vcnt};
    end
  end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder: directed raster bench on a small-parameter decoder.
// 20 clk/line, 8 lines/frame, 8x4 active pixels.
module tb_vga_timing_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsN;
  logic        vsN;
  logic [2:0]  pix;
  logic        pxValid;
  logic [2:0]  pxData;
  logic [10:0] pxX;
  logic [10:0] pxY;
  logic        frameStart;
  logic        locked;
  logic        err;
  logic [11:0] lineLen;
  logic [11:0] frameLines;

  int nVec   = 0;
  int nBad   = 0;
  int beats  = 0;
  int errCnt = 0;
  int expX   = 0;
  int expY   = 0;
  int b0;
  int e0;

  always #5 clk = ~clk;

  vga_timing_decoder #(
    .H_ACTIVE(8),
    .V_ACTIVE(4),
    .H_SYNC_BACK(5),
    .V_SYNC_BACK(2),
    .LOCK_FRAMES(2),
    .PIX_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hsync_n(hsN),
    .vsync_n(vsN),
    .pixel_in(pix),
    .px_valid(pxValid),
    .px_data(pxData),
    .px_x(pxX),
    .px_y(pxY),
    .frame_start(frameStart),
    .locked(locked),
    .err(err),
    .line_len(lineLen),
    .frame_lines(frameLines)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d, want %0d",
               tag, obs, exp);
    end
  endtask

  // pixel at line l, column c is (c + 3*l) & 7; row y is line y+2, x is c-5
  always @(negedge clk) begin
    if (err)
      errCnt++;
    if (pxValid) begin
      check("px_x", pxX, expX);
      check("px_y", pxY, expY);
      check("px_data", pxData,
            (expX + 5 + 3 * (expY + 2)) & 7);
      check("frame_start", frameStart,
            (expX == 0 && expY == 0));
      beats++;
      if (expX == 7) begin
        expX = 0;
        expY = (expY == 3) ? 0 : expY + 1;
      end else begin
        expX++;
      end
    end else if (frameStart) begin
      check("fs_stray", frameStart, 0);
    end
    if (!locked || rst) begin
      expX = 0;
      expY = 0;
    end
  end

  task automatic frame(input bit coinc,
                       input int longL,
                       input bit lockChk,
                       input int rstLine);
    int vsCol;
    vsCol = coinc ? 0 : 15;
    for (int l = 0; l < 8; l++) begin
      int len;
      len = (l == longL) ? 21 : 20;
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        #1;
        if (rst) begin
          check("rst_outs",
                {pxValid, pxData, pxX, pxY,
                 frameStart, locked, err,
                 lineLen, frameLines}, 0);
          rst = 1'b0;
        end
        if (lockChk && l == 0 && c == vsCol + 1)
          check("lock_early", locked, 0);
        if (lockChk && l == 0 && c == vsCol + 2)
          check("lock_rise", locked, 1);
        if (longL >= 0 && l == longL + 1) begin
          if (c == 1) begin
            check("err_pre", err, 0);
            check("lock_pre", locked, 1);
          end
          if (c == 2) begin
            check("err_pulse", err, 1);
            check("lock_drop", locked, 0);
          end
          if (c == 3)
            check("err_end", err, 0);
        end
        hsN = (c >= 2);
        if (coinc)
          vsN = (l != 0);
        else
          vsN = !((l == 0 && c >= 15) ||
                  (l == 1 && c < 15));
        pix = 3'((c + 3 * l) & 7);
        if (l == rstLine && c == 7)
          rst = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    hsN = 1'b1;
    vsN = 1'b1;
    pix = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {pxValid, pxData, pxX, pxY,
           frameStart, locked, err,
           lineLen, frameLines}, 0);
    rst = 1'b0;

    repeat (3) frame(0, -1, 0, -1);
    check("prelock_locked", locked, 0);
    check("prelock_beats", beats, 0);

    b0 = beats;
    frame(0, -1, 1, -1);
    check("lock_beats", beats - b0, 32);
    check("line_len", lineLen, 20);
    check("frame_lines", frameLines, 8);

    b0 = beats;
    frame(0, -1, 0, -1);
    check("steady_beats", beats - b0, 32);

    b0 = beats;
    frame(0, 3, 0, -1);
    check("pert_beats", beats - b0, 16);

    b0 = beats;
    repeat (3) frame(0, -1, 0, -1);
    check("relock_wait_beats", beats - b0, 0);
    check("relock_wait_lock", locked, 0);
    b0 = beats;
    frame(0, -1, 1, -1);
    check("relock_beats", beats - b0, 32);

    b0 = beats;
    e0 = errCnt;
    repeat (5000) begin
      @(posedge clk);
      #1;
      hsN = 1'b1;
      vsN = 1'b1;
    end
    check("hold_err", errCnt - e0, 1);
    check("hold_lock", locked, 0);
    check("hold_beats", beats - b0, 0);

    repeat (3) frame(0, -1, 0, -1);
    frame(0, -1, 1, -1);
    frame(0, -1, 0, 3);
    b0 = beats;
    repeat (3) frame(0, -1, 0, -1);
    check("post_rst_beats", beats - b0, 0);
    check("post_rst_lock", locked, 0);
    b0 = beats;
    frame(0, -1, 1, -1);
    check("post_rst_relock", beats - b0, 32);

    e0 = errCnt;
    frame(1, -1, 0, -1);
    check("mode_err", errCnt - e0, 1);
    check("mode_lock", locked, 0);
    repeat (3) frame(1, -1, 0, -1);
    b0 = beats;
    frame(1, -1, 1, -1);
    check("coinc_beats", beats - b0, 32);
    check("coinc_lines", frameLines, 7);
    check("coinc_len", lineLen, 20);

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nBad);
    $finish;
  end

endmodule
